// File: rtl/stack_unit.sv
// ============================================================================
// Module      : stack_unit
// Description : Hardware stack controller that owns SP and sequences push/pop
//               memory accesses. Optional peek read via STACK_UNIT_PEEK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_unit #(
  parameter int                 WIDTH    = 16,
  parameter logic [0:WIDTH-1]   SP_BASE  = 16'h0000,
  parameter logic [0:WIDTH-1]   SP_LIMIT = 16'hFF00
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [0:WIDTH-1]   i_data,
  output logic               o_ready,
  output logic [0:WIDTH-1]   o_data,
  output logic               o_valid,
  output logic [0:WIDTH-1]   o_sp,
  output logic               o_overflow,
  output logic               o_underflow,
  output logic [0:WIDTH-1]   o_mem_addr,
  output logic [0:WIDTH-1]   o_mem_wdata,
  output logic               o_mem_we,
  output logic               o_mem_re,
  input  logic [0:WIDTH-1]   i_mem_rdata,
  input  logic               i_mem_ack
`ifdef STACK_UNIT_PEEK_EN
  ,
  input  logic               i_peek
`endif
);

  localparam logic [0:WIDTH-1] c_one = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [0:WIDTH-1]   sp_q, sp_d;
  logic [0:WIDTH-1]   addr_q, addr_d;
  logic [0:WIDTH-1]   wdata_q, wdata_d;
  logic [0:WIDTH-1]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               peek_q, peek_d;
  logic               w_peek;

`ifdef STACK_UNIT_PEEK_EN
  assign w_peek = i_peek;
`else
  assign w_peek = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      sp_q    <= SP_BASE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      peek_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      peek_q  <= peek_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    peek_d  = peek_q;

    unique case (state_q)
      IDLE: begin
        // Push has priority; a simultaneous pop/peek is dropped.
        if (i_push) begin
          if (sp_q == SP_LIMIT) begin
            ovf_d = 1'b1;
          end else begin
            addr_d  = sp_q - c_one;
            wdata_d = i_data;
            state_d = WRITE;
          end
        end else if (i_pop || w_peek) begin
          if (sp_q == SP_BASE) begin
            unf_d = 1'b1;
          end else begin
            addr_d  = sp_q;
            peek_d  = !i_pop;
            state_d = READ;
          end
        end
      end
      WRITE: begin
        if (i_mem_ack) begin
          sp_d    = sp_q - c_one;
          state_d = IDLE;
        end
      end
      READ: begin
        if (i_mem_ack) begin
          data_d  = i_mem_rdata;
          valid_d = 1'b1;
          if (!peek_q) begin
            sp_d = sp_q + c_one;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state so reset drops them asynchronously.
  assign o_ready     = (state_q == IDLE);
  assign o_mem_we    = (state_q == WRITE);
  assign o_mem_re    = (state_q == READ);
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_sp        = sp_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

`default_nettype wire
